// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store sequencer.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERR   = 3'd5
  } mau_state_t;

  function automatic logic is_load(input mem_op_t op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Byte and half stores need the old word first (read-modify-write).
  function automatic logic is_sub_word(input mem_op_t op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_half(input mem_op_t op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input mem_op_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
    return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
  endfunction

  // Offset with the low bits cleared to the natural alignment of the access size.
  function automatic logic [1:0] align_off(input mem_op_t op, input logic [1:0] off);
    if (is_word(op)) return 2'b00;
    if (is_half(op)) return {off[1], 1'b0};
    return off;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extraction/extension and sub-word store merge.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  off_i,
  input  mem_op_t     op_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the word and extend it to 32 bits.
  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    unique case (op_i)
      OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_o = {24'd0, byte_sel};
      OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Replace the addressed byte/half of the old word with the store data.
  always_comb begin
    merge_o = word_i;
    if (op_i == OP_SB) begin
      merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (op_i == OP_SH) begin
      if (off_i[1]) merge_o[31:16] = wdata_i;
      else          merge_o[15:0]  = wdata_i;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-only data memory.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic [31:0] dmem_a_o,
  output logic [31:0] dmem_wd_o,
  output logic        dmem_we_o,
  input  logic [31:0] dmem_rd_i
);

  mau_state_t  state_q, state_d;
  mem_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] load_word;
  logic [31:0] merge_word;
  mem_op_t     req_op;

  assign req_op  = mem_op_t'(op_i);
  assign rdata_o = rdata_q;

  mem_lane_align u_align (
    .word_i  (dmem_rd_i),
    .wdata_i (wdata_q[15:0]),
    .off_i   (addr_q[1:0]),
    .op_i    (op_q),
    .load_o  (load_word),
    .merge_o (merge_word)
  );

  // Control state plus the registers the spec gives a reset value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'd0;
      merge_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  // Request capture; only loaded in IDLE so no reset value is needed.
  always_ff @(posedge clk_i) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Next state and dmem/handshake outputs; reset blocks writes and acks at once.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    merge_d    = merge_q;
    ack_o      = 1'b0;
    misalign_o = 1'b0;
    dmem_we_o  = 1'b0;
    dmem_wd_o  = 32'd0;
    dmem_a_o   = {addr_q[31:2], 2'b00};

    unique case (state_q)
      ST_IDLE: begin
        dmem_a_o = 32'd0;
        if (req_i) begin
          op_d    = req_op;
          wdata_d = wdata_i;
          // When misalignment is tolerated, the access silently snaps to alignment.
          addr_d  = ERR_ON_MISALIGN ? addr_i
                                    : {addr_i[31:2], align_off(req_op, addr_i[1:0])};
          if (ERR_ON_MISALIGN && is_misaligned(req_op, addr_i[1:0])) state_d = ST_ERR;
          else if (is_load(req_op))                                  state_d = ST_LOAD;
          else if (is_sub_word(req_op))                              state_d = ST_READ;
          else                                                       state_d = ST_STORE;
        end
      end
      ST_LOAD: begin
        ack_o   = 1'b1;
        rdata_d = load_word;
        state_d = ST_IDLE;
      end
      ST_STORE: begin
        ack_o     = 1'b1;
        dmem_we_o = 1'b1;
        dmem_wd_o = wdata_q;
        state_d   = ST_IDLE;
      end
      ST_READ: begin
        merge_d = merge_word;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ack_o     = 1'b1;
        dmem_we_o = 1'b1;
        dmem_wd_o = merge_q;
        state_d   = ST_IDLE;
      end
      ST_ERR: begin
        ack_o      = 1'b1;
        misalign_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst_i) begin
      dmem_we_o  = 1'b0;
      ack_o      = 1'b0;
      misalign_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        ack, mis, we;
  logic [31:0] rdata, da, dwd, drd;

  logic        req0;
  logic [2:0]  op0;
  logic [31:0] addr0, wdata0;
  logic        ack0, mis0, we0;
  logic [31:0] rdata0, da0, dwd0, drd0;

  logic        mem_init = 1'b1;
  logic [31:0] mem [0:63];
  int          wr_count = 0;

  logic [7:0]  ref_b [0:255];
  logic [31:0] rexp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h8899AABB;
    if (i == 9) return 32'h11223344;
    return (i * 32'h01010101) ^ 32'h5A3C0F96;
  endfunction

  // Bench data memory: combinational read, synchronous write.
  assign drd  = mem[da[7:2]];
  assign drd0 = init_word(int'(da0[7:2]));

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (we) begin
      mem[da[7:2]] <= dwd;
      wr_count     <= wr_count + 1;
    end
  end

  mem_access_unit #(.ERR_ON_MISALIGN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .misalign_o(mis), .dmem_a_o(da), .dmem_wd_o(dwd),
    .dmem_we_o(we), .dmem_rd_i(drd)
  );

  mem_access_unit #(.ERR_ON_MISALIGN(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .op_i(op0), .addr_i(addr0), .wdata_i(wdata0),
    .ack_o(ack0), .rdata_o(rdata0), .misalign_o(mis0), .dmem_a_o(da0), .dmem_wd_o(dwd0),
    .dmem_we_o(we0), .dmem_rd_i(drd0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: memory as bytes, accesses by size ----
  function automatic int op_size(input logic [2:0] o);
    if (o == OP_LB || o == OP_LBU || o == OP_SB) return 1;
    if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic op_is_store(input logic [2:0] o);
    return (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] o, input logic [31:0] a);
    return (a % op_size(o)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input int widx);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_b[4*widx + k];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a);
    logic [31:0] v;
    int          sz;
    sz = op_size(o);
    v  = 32'd0;
    for (int k = 0; k < sz; k++) v = v | (32'(ref_b[a[7:0] + k]) << (8 * k));
    if (o == OP_LB && v[7])  v = v | 32'hFFFFFF00;
    if (o == OP_LH && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < op_size(o); k++) ref_b[a[7:0] + k] = 8'(d >> (8 * k));
  endtask

  // Issue one op, wait (bounded) for ack, then check latency, flags, data and memory.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    int          n, w0, exp_n;
    logic        seen, got_mis, got_we, misal, st;
    logic [31:0] got_da, got_wd;
    misal = ref_misaligned(o, a);
    st    = op_is_store(o);
    exp_n = (!misal && (o == OP_SB || o == OP_SH)) ? 2 : 1;
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = d;
    w0 = wr_count;
    seen = 1'b0; n = 0; got_mis = 1'b0; got_we = 1'b0; got_da = '0; got_wd = '0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (ack) begin
        seen = 1'b1; got_mis = mis; got_we = we; got_da = da; got_wd = dwd;
      end else begin
        chk("we_without_ack", 32'(we), 32'd0);
      end
    end
    req = 1'b0;
    chk("ack_seen", 32'(seen), 32'd1);
    chk("latency", n, exp_n);
    chk("misalign", 32'(got_mis), 32'(misal));
    chk("we_at_ack", 32'(got_we), 32'(st && !misal));
    chk("addr_at_ack", got_da, {a[31:2], 2'b00});
    if (!misal) begin
      if (st) begin
        ref_store(o, a, d);
        chk("wdata_at_ack", got_wd, ref_word(int'(a[7:2])));
      end else begin
        rexp = ref_load(o, a);
      end
    end
    @(negedge clk);
    chk("rdata", rdata, rexp);
    chk("write_count", wr_count - w0, (st && !misal) ? 1 : 0);
    chk("mem_word", mem[a[7:2]], ref_word(int'(a[7:2])));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          ack_cyc [3];
    int          k, c, w0;
    logic [2:0]  ro;
    logic [31:0] ra;

    rst = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;
    req0 = 1'b0; op0 = '0; addr0 = '0; wdata0 = '0;
    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_b[4*i + b] = w[8*b +: 8];
    end
    rexp = 32'd0;

    // Reset: every output is zero the cycle after.
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0; rst = 1'b0;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", da, 32'd0);
    chk("rst_wd", dwd, 32'd0);

    // Loads with extension.
    run_op(OP_LB,  32'h11, 32'd0); chk("tp_lb",  rdata, 32'hFFFFFFAA);
    run_op(OP_LBU, 32'h11, 32'd0); chk("tp_lbu", rdata, 32'h000000AA);
    run_op(OP_LH,  32'h12, 32'd0); chk("tp_lh",  rdata, 32'hFFFF8899);
    run_op(OP_LHU, 32'h12, 32'd0); chk("tp_lhu", rdata, 32'h00008899);
    run_op(OP_LW,  32'h10, 32'd0); chk("tp_lw",  rdata, 32'h8899AABB);

    // Full-word store then read back.
    run_op(OP_SW, 32'h20, 32'hDEADBEEF);
    run_op(OP_LW, 32'h20, 32'd0); chk("tp_sw_lw", rdata, 32'hDEADBEEF);

    // Sub-word read-modify-write.
    run_op(OP_SB, 32'h27, 32'h000000CC); chk("tp_sb", mem[9], 32'hCC223344);
    run_op(OP_SH, 32'h24, 32'h00005566); chk("tp_sh", mem[9], 32'hCC225566);

    // Misaligned ops are suppressed; rdata keeps the last load result.
    run_op(OP_SH, 32'h21, 32'h0000FFFF); chk("tp_sh_mis_mem", mem[8], 32'hDEADBEEF);
    run_op(OP_LW, 32'h22, 32'd0);        chk("tp_lw_mis_rdata", rdata, 32'hDEADBEEF);

    // Reset during the READ cycle of SB 0x24: dropped, no write, no ack.
    w0 = wr_count;
    @(negedge clk); req = 1'b1; op = OP_SB; addr = 32'h24; wdata = 32'h000000EE;
    @(negedge clk); rst = 1'b1; req = 1'b0;
    #1;
    chk("rst_read_we", 32'(we), 32'd0);
    chk("rst_read_ack", 32'(ack), 32'd0);
    @(negedge clk); rst = 1'b0;
    rexp = 32'd0;
    chk("rst_read_idle_addr", da, 32'd0);
    chk("rst_read_idle_ack", 32'(ack), 32'd0);
    chk("rst_read_rdata", rdata, 32'd0);
    @(negedge clk);
    chk("rst_read_mem", mem[9], 32'hCC225566);
    chk("rst_read_writes", wr_count - w0, 32'd0);

    // Reset during the WRITE cycle: the write enable must drop immediately.
    w0 = wr_count;
    @(negedge clk); req = 1'b1; op = OP_SB; addr = 32'h31; wdata = 32'h00000012;
    @(negedge clk); req = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_write_we", 32'(we), 32'd0);
    chk("rst_write_ack", 32'(ack), 32'd0);
    @(negedge clk); rst = 1'b0;
    chk("rst_write_ack_after", 32'(ack), 32'd0);
    @(negedge clk);
    chk("rst_write_mem", mem[12], ref_word(12));
    chk("rst_write_writes", wr_count - w0, 32'd0);

    // Back-to-back LW/SB/LW with req held throughout.
    @(negedge clk); req = 1'b1; op = OP_LW; addr = 32'h10; wdata = 32'd0;
    k = 0; c = 0;
    while (k < 3 && c < 12) begin
      @(negedge clk);
      c++;
      if (ack) begin
        ack_cyc[k] = c;
        k++;
        if (k == 1) begin op = OP_SB; addr = 32'h10; wdata = 32'h00000077; end
        if (k == 2) begin op = OP_LW; addr = 32'h10; wdata = 32'd0; end
        if (k == 3) req = 1'b0;
      end
    end
    chk("b2b_ack_count", k, 32'd3);
    if (k == 3) begin
      chk("b2b_ack0", ack_cyc[0], 32'd1);
      chk("b2b_ack1", ack_cyc[1], 32'd4);
      chk("b2b_ack2", ack_cyc[2], 32'd6);
    end
    ref_store(OP_SB, 32'h10, 32'h77);
    rexp = ref_load(OP_LW, 32'h10);
    @(negedge clk);
    chk("b2b_rdata", rdata, 32'h8899AA77);
    chk("b2b_rdata_model", rdata, rexp);

    // Tolerant instance: misaligned accesses snap to alignment and proceed.
    @(negedge clk); req0 = 1'b1; op0 = OP_LW; addr0 = 32'h22;
    @(negedge clk);
    chk("noerr_lw_ack", 32'(ack0), 32'd1);
    chk("noerr_lw_mis", 32'(mis0), 32'd0);
    chk("noerr_lw_addr", da0, 32'h20);
    req0 = 1'b0;
    @(negedge clk);
    chk("noerr_lw_rdata", rdata0, init_word(8));
    req0 = 1'b1; op0 = OP_LH; addr0 = 32'h13;
    @(negedge clk);
    chk("noerr_lh_ack", 32'(ack0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("noerr_lh_rdata", rdata0, 32'hFFFF8899);
    chk("noerr_we", 32'(we0), 32'd0);

    // Random traffic against the byte model, biased toward aligned addresses.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) ra = ra & ~32'(op_size(ro) - 1);
      run_op(ro, ra, $urandom);
    end

    // Whole-memory comparison against the model.
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer between the pipeline MEM stage and the word-only data memory, which is word-addressed via address bits [31:2], has a combinational read and a full-word synchronous write.
- Turns MIPS LB/LBU/LH/LHU/LW/SB/SH/SW into word accesses.
- Sub-word stores are done as read-modify-write.
- Performs load byte/half selection with sign or zero extension.
- Flags misaligned accesses.
- Pipeline holds the request stable until ack_o.

Parameters:
ERR_ON_MISALIGN, 1, 1: misaligned op is suppressed and flagged; 0: low address bits are forced to alignment (half: bit0=0; word: bits1:0=0) and the access proceeds.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
req_i  in  1  memory op valid; held with op_i/addr_i/wdata_i stable until ack_o
op_i  in  3  mem_op_t: LB, LBU, LH, LHU, LW, SB, SH, SW
addr_i  in  32  byte address
wdata_i  in  32  store data; SB uses [7:0], SH uses [15:0]
ack_o  out  1  op completes at this clock edge
rdata_o  out  32  registered load result, held until the next load completes
misalign_o  out  1  high with ack_o when the op was misaligned and suppressed
dmem_a_o  out  32  byte address to dmem, always word-aligned
dmem_wd_o  out  32  write word to dmem
dmem_we_o  out  1  dmem write enable
dmem_rd_i  in  32  dmem combinational read word

Behaviour:
- Byte order: little-endian; byte k of a word is bits [8k+7:8k].
- States: IDLE, LOAD, STORE, READ, WRITE, ERR.
- IDLE: ack_o=0, dmem_we_o=0, dmem_a_o=0. On req_i, latch op, addr and wdata, then go to:
  - ERR if misaligned and ERR_ON_MISALIGN=1. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - LOAD for loads.
  - STORE for SW.
  - READ for SB/SH.
- Outside IDLE, dmem_a_o = {latched addr[31:2], 2'b00}.
- LOAD:
  - ack_o=1.
  - At the edge, rdata_o <= extract(dmem_rd_i). Selection uses addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Next state IDLE.
- STORE: ack_o=1, dmem_we_o=1, dmem_wd_o=latched wdata. Next state IDLE.
- READ: ack_o=0, dmem_we_o=0. At the edge, merge reg <= dmem_rd_i with the target byte/half replaced by wdata[7:0] or wdata[15:0]. Next state WRITE.
- WRITE: ack_o=1, dmem_we_o=1, dmem_wd_o=merge reg. Next state IDLE.
- ERR: ack_o=1, misalign_o=1, dmem_we_o=0, rdata_o unchanged. Next state IDLE.
- Latency from acceptance edge to ack edge:
  - Loads, SW, misaligned ops: 2 cycles (accept cycle plus ack cycle).
  - SB/SH: 3 cycles.
- Back-to-back ops: a held or new req_i is accepted in the first IDLE cycle after ack. Requests are never accepted in non-IDLE states.
- req_i deasserted mid-op: the op still completes; ack_o is still issued.
- dmem_we_o is high only in STORE/WRITE. Exactly one write per store.
- Stores do not modify rdata_o.
- Reset:
  - While rst_i=1, dmem_we_o is forced 0 combinationally, including mid-WRITE/STORE.
  - At the edge: state=IDLE, rdata_o=0, merge reg=0.
  - All outputs are 0 in the cycle after reset.
  - An in-flight op is dropped with no ack.
- dmem_wd_o is 0 outside STORE/WRITE.
- misalign_o is 0 outside ERR.

Decomposition:
- Package mem_pkg:
  - mem_op_t enum (3-bit).
  - mau_state_t enum.
  - Helper functions: is_load, is_sub_word, size-based misalign check.
- One combinational sub-module, mem_lane_align, contains:
  - load extract/extend (word, addr[1:0], op -> 32b).
  - store merge (old word, wdata, addr[1:0], op -> 32b).
- The FSM and registers stay in mem_access_unit.

Test Plan:
1. dmem[0x10]=0x8899AABB. Expected rdata_o, each with ack 2 cycles after accept:
   - LB 0x11 -> 0xFFFFFFAA
   - LBU 0x11 -> 0x000000AA
   - LH 0x12 -> 0xFFFF8899
   - LHU 0x12 -> 0x00008899
   - LW 0x10 -> 0x8899AABB
2. SW 0x20 with 0xDEADBEEF -> one dmem_we_o pulse in the cycle after accept with dmem_a_o=0x20, dmem_wd_o=0xDEADBEEF. A following LW 0x20 returns 0xDEADBEEF.
3. dmem[0x24]=0x11223344:
   - SB 0x27 with 0x000000CC -> no write in READ; WRITE writes 0xCC223344 to 0x24; ack 3 cycles after accept.
   - Then SH 0x24 with 0x5566 -> 0xCC225566.
4. Misaligned, ERR_ON_MISALIGN=1:
   - SH 0x21 -> ack_o=1, misalign_o=1, dmem_we_o never high, memory unchanged.
   - LW 0x22 -> misalign_o=1, rdata_o keeps its prior value.
   - With ERR_ON_MISALIGN=0, LW 0x22 reads word 0x20.
5. Assert rst_i during the READ cycle of SB 0x24 -> no dmem_we_o, no ack_o; state is IDLE and rdata_o=0 the next cycle; dmem[0x24] unchanged.
6. LW 0x10, SB 0x10, LW 0x10 issued back-to-back with req_i held continuously -> acks at cycles 2, 5 and 7 after the first accept, and the final rdata_o reflects the merged byte.
